// File: rtl/minterm_scan_ctrl.sv
// Scan controller for a 4-input combinational block: walks all 16 minterms,
// waits SETTLE_CYCLES per vector, samples the block output into a truth table
// and counts the bits that differ from an expected pattern latched at start.
module minterm_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_count,
  output logic        match
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // Counter reload: SETTLE lasts SETTLE_CYCLES cycles because it counts down to 0 inclusive.
  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mm_q, mm_d;
  logic [4:0]  mm_next;
  logic        match_q, match_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Mismatch count including the current sample; saturates at 16.
  always_comb begin
    mm_next = mm_q;
    if ((f_in != exp_q[index_q]) && (mm_q != 5'd16)) begin
      mm_next = mm_q + 5'd1;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    mm_d    = mm_q;
    match_d = match_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          exp_d   = expected;
          tt_d    = 16'h0000;
          mm_d    = 5'd0;
          match_d = 1'b0;
          index_d = 4'd0;
          cnt_d   = SettleLoad;
          busy_d  = 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StSample;
        end
      end
      StSample: begin
        tt_d[index_q] = f_in;
        mm_d          = mm_next;
        if (index_q == 4'd15) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (mm_next == 5'd0);
        end else begin
          state_d = StSettle;
          index_d = index_q + 4'd1;
          cnt_d   = SettleLoad;
        end
      end
      StDone: begin
        // Index doubles as the A..D drive, so clearing it returns the inputs to 0000.
        state_d = StIdle;
        index_d = 4'd0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      index_q <= 4'd0;
      cnt_q   <= 8'd0;
      exp_q   <= 16'h0000;
      tt_q    <= 16'h0000;
      mm_q    <= 5'd0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      mm_q    <= mm_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {A, B, C, D}   = index_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign truth_table    = tt_q;
  assign mismatch_count = mm_q;
  assign match          = match_q;

endmodule
